// File: rtl/calc_mport_pkg.sv
// rtl/calc_mport_pkg.sv - shared encodings, default parameters and width helpers for calc_mport
// Contents:
//   CMD_W, RESP_W        - per-port command and response field widths
//   cmd_e, resp_e        - command and response code encodings
//   DEF_*                - default parameter values
//   port_w(), shamt_w()  - widths derived from NUM_PORTS and DATA_W
package calc_mport_pkg;

  localparam int CMD_W  = 4;
  localparam int RESP_W = 2;

  localparam int DEF_NUM_PORTS = 4;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_QDEPTH    = 2;
  localparam int DEF_ALU_LAT   = 2;

  typedef enum logic [CMD_W-1:0] {
    CMD_IDLE = 4'd0,
    CMD_ADD  = 4'd1,
    CMD_SUB  = 4'd2,
    CMD_SHL  = 4'd5,
    CMD_SHR  = 4'd6
  } cmd_e;

  typedef enum logic [RESP_W-1:0] {
    RESP_NONE = 2'd0,
    RESP_OK   = 2'd1,
    RESP_ERR  = 2'd2
  } resp_e;

  // Width of a port tag.
  function automatic int port_w(input int num_ports);
    return (num_ports > 1) ? $clog2(num_ports) : 1;
  endfunction

  // Width of the shift-amount field of operand2.
  function automatic int shamt_w(input int data_w);
    return $clog2(data_w);
  endfunction

endpackage

// File: rtl/calc_mport_if.sv
// rtl/calc_mport_if.sv - requester/response bus bundle for calc_mport
// Signals (flattened per port, port p occupies slice p):
//   req_cmd_in   - command code, 0 = idle
//   req_data_in  - operand1 on the command cycle, operand2 on the following cycle
//   req_busy     - backpressure; a command presented while high is dropped
//   out_resp     - response code (0 none, 1 success, 2 overflow/invalid)
//   out_data     - result, non-zero only alongside a response
// Modports: master (requester side), slave (calculator side).
interface calc_mport_if
  import calc_mport_pkg::*;
#(
  parameter int NUM_PORTS = DEF_NUM_PORTS,
  parameter int DATA_W    = DEF_DATA_W
);

  logic [NUM_PORTS*CMD_W-1:0]  req_cmd_in;
  logic [NUM_PORTS*DATA_W-1:0] req_data_in;
  logic [NUM_PORTS-1:0]        req_busy;
  logic [NUM_PORTS*RESP_W-1:0] out_resp;
  logic [NUM_PORTS*DATA_W-1:0] out_data;

  modport master (
    output req_cmd_in, req_data_in,
    input  req_busy, out_resp, out_data
  );

  modport slave (
    input  req_cmd_in, req_data_in,
    output req_busy, out_resp, out_data
  );

endinterface

// File: rtl/calc_mport_rr_arb.sv
// rtl/calc_mport_rr_arb.sv - round-robin arbiter selecting one requesting port per cycle
// Ports:
//   c_clk     - clock, rising edge
//   reset     - asynchronous active-high reset, pointer returns to port 0
//   req       - per-port request (queue non-empty)
//   gnt_valid - a grant is issued this cycle
//   gnt_idx   - granted port index
module calc_mport_rr_arb
  import calc_mport_pkg::*;
#(
  parameter int NUM_PORTS = DEF_NUM_PORTS
) (
  input  logic                         c_clk,
  input  logic                         reset,
  input  logic [NUM_PORTS-1:0]         req,
  output logic                         gnt_valid,
  output logic [port_w(NUM_PORTS)-1:0] gnt_idx
);

  localparam int PORT_W = port_w(NUM_PORTS);

  logic [PORT_W-1:0] ptr;
  logic [PORT_W-1:0] idx;

  // Scan from the farthest offset to the nearest so the requester closest
  // to ptr (in wrap-around order) is the one left in gnt_idx.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    idx       = '0;
    for (int off = NUM_PORTS - 1; off >= 0; off--) begin
      idx = PORT_W'((int'(ptr) + off) % NUM_PORTS);
      if (req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = idx;
      end
    end
  end

  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (gnt_valid) begin
      ptr <= (gnt_idx == PORT_W'(NUM_PORTS - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/calc_mport.sv
// rtl/calc_mport.sv - multi-port calculator: per-port capture and queues, round-robin issue, ALU pipeline
// Ports:
//   c_clk - clock, rising edge
//   reset - asynchronous active-high reset; drops every queued and in-flight command
//   bus   - calc_mport_if.slave: per-port command/operands in, busy, response code and result out
module calc_mport
  import calc_mport_pkg::*;
#(
  parameter int NUM_PORTS = DEF_NUM_PORTS,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int QDEPTH    = DEF_QDEPTH,
  parameter int ALU_LAT   = DEF_ALU_LAT
) (
  input  logic        c_clk,
  input  logic        reset,
  calc_mport_if.slave bus
);

  localparam int PORT_W  = port_w(NUM_PORTS);
  localparam int SHAMT_W = shamt_w(DATA_W);
  localparam int QCNT_W  = $clog2(QDEPTH + 1);
  localparam int QIDX_W  = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

  typedef struct packed {
    logic [CMD_W-1:0]  cmd;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
  } entry_t;

  typedef struct packed {
    logic              valid;
    logic [PORT_W-1:0] port;
    entry_t            ent;
  } pipe_t;

  entry_t [NUM_PORTS-1:0] head;
  logic   [NUM_PORTS-1:0] head_valid;
  logic                   gnt_valid;
  logic   [PORT_W-1:0]    gnt_idx;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic [CMD_W-1:0]  cmd_in;
    logic [DATA_W-1:0] data_in;
    logic              cap;      // operand2 arrives this cycle
    logic [CMD_W-1:0]  cap_cmd;
    logic [DATA_W-1:0] cap_op1;
    entry_t            mem [QDEPTH];
    logic [QIDX_W-1:0] rd_ptr;
    logic [QIDX_W-1:0] wr_ptr;
    logic [QCNT_W-1:0] cnt;
    logic [QCNT_W:0]   occ;
    logic              busy;
    logic              accept;
    logic              deq;

    assign cmd_in  = bus.req_cmd_in[p*CMD_W +: CMD_W];
    assign data_in = bus.req_data_in[p*DATA_W +: DATA_W];

    // A capture in progress reserves a slot, so busy rises one cycle
    // before the entry actually lands in the queue.
    assign occ    = {1'b0, cnt} + {{QCNT_W{1'b0}}, cap};
    assign busy   = (occ == (QCNT_W + 1)'(QDEPTH));
    // The command field is ignored during the operand2 cycle.
    assign accept = (cmd_in != '0) && !busy && !cap;
    assign deq    = gnt_valid && (gnt_idx == PORT_W'(p));

    assign head[p]         = mem[rd_ptr];
    assign head_valid[p]   = (cnt != '0);
    assign bus.req_busy[p] = busy;

    always_ff @(posedge c_clk or posedge reset) begin
      if (reset) begin
        cap     <= 1'b0;
        cap_cmd <= '0;
        cap_op1 <= '0;
        rd_ptr  <= '0;
        wr_ptr  <= '0;
        cnt     <= '0;
      end else begin
        cap <= accept;
        if (accept) begin
          cap_cmd <= cmd_in;
          cap_op1 <= data_in;
        end
        if (cap) begin
          wr_ptr <= (wr_ptr == QIDX_W'(QDEPTH - 1)) ? '0 : wr_ptr + 1'b1;
        end
        if (deq) begin
          rd_ptr <= (rd_ptr == QIDX_W'(QDEPTH - 1)) ? '0 : rd_ptr + 1'b1;
        end
        if (cap && !deq) begin
          cnt <= cnt + 1'b1;
        end else if (!cap && deq) begin
          cnt <= cnt - 1'b1;
        end
      end
    end

    always_ff @(posedge c_clk) begin
      if (cap) begin
        mem[wr_ptr] <= {cap_cmd, cap_op1, data_in};
      end
    end
  end

  calc_mport_rr_arb #(
    .NUM_PORTS (NUM_PORTS)
  ) u_arb (
    .c_clk     (c_clk),
    .reset     (reset),
    .req       (head_valid),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // Pipeline carries operands only; the result is formed at the last stage.
  pipe_t pipe [ALU_LAT];

  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ALU_LAT; i++) begin
        pipe[i] <= '0;
      end
    end else begin
      pipe[0] <= '{valid: gnt_valid, port: gnt_idx, ent: head[gnt_idx]};
      for (int i = 1; i < ALU_LAT; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  pipe_t             ex;
  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] res;
  logic              err;

  assign ex = pipe[ALU_LAT-1];

  always_comb begin
    sum = {1'b0, ex.ent.op1} + {1'b0, ex.ent.op2};
    res = '0;
    err = 1'b0;
    case (ex.ent.cmd)
      CMD_ADD: begin
        res = sum[DATA_W-1:0];
        err = sum[DATA_W];
      end
      CMD_SUB: begin
        res = ex.ent.op1 - ex.ent.op2;
        err = (ex.ent.op2 > ex.ent.op1);
      end
      CMD_SHL: begin
        res = ex.ent.op1 << ex.ent.op2[SHAMT_W-1:0];
        err = |(ex.ent.op2 >> SHAMT_W);
      end
      CMD_SHR: begin
        res = ex.ent.op1 >> ex.ent.op2[SHAMT_W-1:0];
        err = |(ex.ent.op2 >> SHAMT_W);
      end
      default: err = 1'b1;
    endcase
    if (err) begin
      res = '0;
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_out
    logic hit;
    assign hit = ex.valid && (ex.port == PORT_W'(p));
    assign bus.out_resp[p*RESP_W +: RESP_W] = hit ? (err ? RESP_ERR : RESP_OK) : RESP_NONE;
    assign bus.out_data[p*DATA_W +: DATA_W] = hit ? res : '0;
  end

endmodule

// File: tb/tb_calc_mport.sv
// tb/tb_calc_mport.sv - randomized scoreboard bench for calc_mport against a queue-based reference model
module tb_calc_mport;
  import calc_mport_pkg::*;

  localparam int NP = 4;
  localparam int DW = 32;
  localparam int QD = 2;
  localparam int AL = 2;
  localparam longint unsigned MASK = (64'd1 << DW) - 1;

  logic c_clk = 1'b0;
  logic reset;

  calc_mport_if #(.NUM_PORTS(NP), .DATA_W(DW)) bus ();

  calc_mport #(
    .NUM_PORTS (NP),
    .DATA_W    (DW),
    .QDEPTH    (QD),
    .ALU_LAT   (AL)
  ) dut (
    .c_clk (c_clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 c_clk = ~c_clk;

  typedef struct {
    int unsigned     cmd;
    longint unsigned a;
    longint unsigned b;
  } cmd_t;

  typedef struct {
    int unsigned     resp;
    longint unsigned data;
    int              cyc;
  } exp_t;

  cmd_t mq   [NP][$];   // accepted commands awaiting issue
  exp_t expq [NP][$];   // predicted responses, in return order
  bit   capm [NP];
  cmd_t capc [NP];
  bit   mbusy [NP];
  int   ptr;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always @(posedge c_clk) cyc <= cyc + 1;

  function automatic void chk(string name, longint unsigned act, longint unsigned expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", name, cyc, act, expv);
    end
  endfunction

  function automatic exp_t ref_op(cmd_t c, int at);
    exp_t e;
    e.cyc  = at;
    e.resp = 2;
    e.data = 0;
    case (c.cmd)
      1: if (c.a + c.b <= MASK) begin e.resp = 1; e.data = c.a + c.b; end
      2: if (c.b <= c.a)        begin e.resp = 1; e.data = c.a - c.b; end
      5: if (c.b < DW)          begin e.resp = 1; e.data = (c.a << c.b) & MASK; end
      6: if (c.b < DW)          begin e.resp = 1; e.data = c.a >> c.b; end
      default: ;
    endcase
    return e;
  endfunction

  // Reference model: one step per cycle using the inputs held during it.
  int   mp;
  bit   granted;
  int   mcmd;
  longint unsigned mdata;
  cmd_t mc;

  always @(negedge c_clk) begin
    if (reset) begin
      for (int p = 0; p < NP; p++) begin
        mq[p].delete();
        expq[p].delete();
        capm[p] = 1'b0;
      end
      ptr = 0;
    end else begin
      for (int p = 0; p < NP; p++) begin
        mbusy[p] = ((mq[p].size() + int'(capm[p])) == QD);
        chk($sformatf("busy_p%0d", p), longint'(bus.req_busy[p]), longint'(mbusy[p]));
      end
      granted = 1'b0;
      for (int k = 0; k < NP; k++) begin
        mp = (ptr + k) % NP;
        if (!granted && mq[mp].size() > 0) begin
          granted = 1'b1;
          mc = mq[mp].pop_front();
          expq[mp].push_back(ref_op(mc, cyc + AL));
          ptr = (mp + 1) % NP;
        end
      end
      for (int p = 0; p < NP; p++) begin
        mcmd  = int'(bus.req_cmd_in[p*4 +: 4]);
        mdata = longint'(bus.req_data_in[p*DW +: DW]);
        if (capm[p]) begin
          capc[p].b = mdata;
          mq[p].push_back(capc[p]);
          capm[p] = 1'b0;
        end else if (mcmd != 0 && !mbusy[p]) begin
          capm[p] = 1'b1;
          capc[p].cmd = mcmd;
          capc[p].a = mdata;
        end
      end
    end
  end

  // Monitor: pops a prediction whenever a port presents a response.
  int unsigned     r;
  longint unsigned d;
  exp_t            e;

  always @(negedge c_clk) begin
    if (!reset) begin
      for (int p = 0; p < NP; p++) begin
        r = int'(bus.out_resp[p*2 +: 2]);
        d = longint'(bus.out_data[p*DW +: DW]);
        if (r != 0) begin
          if (expq[p].size() == 0) begin
            chk($sformatf("unexpected_resp_p%0d", p), r, 0);
          end else begin
            e = expq[p].pop_front();
            chk($sformatf("resp_p%0d", p), r, e.resp);
            chk($sformatf("data_p%0d", p), d, e.data);
            chk($sformatf("resp_cycle_p%0d", p), longint'(cyc), longint'(e.cyc));
          end
        end else begin
          if (d != 0) chk($sformatf("idle_data_p%0d", p), d, 0);
          if (expq[p].size() > 0 && expq[p][0].cyc <= cyc) begin
            chk($sformatf("missing_resp_p%0d", p), 0, expq[p][0].resp);
            void'(expq[p].pop_front());
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge c_clk);
    #1;
  endtask

  task automatic drv(int p, int c, longint unsigned v);
    bus.req_cmd_in[p*4 +: 4]   = 4'(c);
    bus.req_data_in[p*DW +: DW] = DW'(v);
  endtask

  task automatic idle_all();
    for (int p = 0; p < NP; p++) drv(p, 0, 0);
  endtask

  task automatic check_zero(string tag);
    chk({tag, "_busy"}, longint'(bus.req_busy), 0);
    chk({tag, "_resp"}, longint'(bus.out_resp), 0);
    chk({tag, "_data"}, longint'(|bus.out_data), 0);
  endtask

  // Pulse reset from mid-cycle; outputs must clear without waiting for a clock.
  task automatic pulse_reset();
    reset = 1'b1;
    idle_all();
    #1;
    check_zero("reset_immediate");
    step();
    step();
    reset = 1'b0;
  endtask

  function automatic int rand_cmd();
    int unsigned k;
    k = $urandom_range(0, 11);
    case (k)
      0, 1, 2, 3, 4: return 0;
      5, 6: return 1;
      7: return 2;
      8: return 5;
      9: return 6;
      10: return 2;
      default: begin
        case ($urandom_range(0, 3))
          0: return 3;
          1: return 4;
          2: return 7;
          default: return 15;
        endcase
      end
    endcase
  endfunction

  function automatic longint unsigned rand_data();
    case ($urandom_range(0, 5))
      0: return MASK;
      1: return longint'($urandom_range(0, 40));
      2: return 1;
      default: return longint'($urandom);
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    idle_all();
    repeat (3) step();
    check_zero("reset_state");
    reset = 1'b0;
    step();

    // Port 0: 3 + 4, uncontended -> resp 1 / 7 in T+4.
    drv(0, 1, 32'h3);
    step();
    drv(0, 0, 32'h4);
    step();
    drv(0, 0, 0);
    step();
    step();
    chk("add_basic_resp", longint'(bus.out_resp), 64'h01);
    chk("add_basic_data", longint'(bus.out_data[DW-1:0]), 7);
    repeat (6) step();

    // Overflow cases: add carry, subtract underflow, shift by DW.
    drv(2, 1, 32'hFFFF_FFFF);
    drv(1, 2, 2);
    drv(0, 5, 1);
    step();
    drv(2, 0, 1);
    drv(1, 0, 5);
    drv(0, 0, 32);
    step();
    idle_all();
    repeat (10) step();

    // All ports at once from a fresh pointer: grants 0,1,2,3.
    pulse_reset();
    step();
    for (int p = 0; p < NP; p++) drv(p, 1, 10 * p);
    step();
    for (int p = 0; p < NP; p++) drv(p, 0, p);
    step();
    idle_all();
    repeat (10) step();

    // Port 3 back-to-back while contended: third command must be dropped.
    pulse_reset();
    step();
    for (int p = 0; p < NP; p++) drv(p, 6, 32'h100);
    step();
    for (int p = 0; p < NP; p++) drv(p, 0, 4);
    step();
    idle_all();
    drv(3, 5, 32'h3);
    step();
    drv(3, 0, 2);
    step();
    drv(3, 2, 50);
    chk("contended_busy_p3", longint'(bus.req_busy[3]), 1);
    step();
    drv(3, 0, 8);
    step();
    idle_all();
    repeat (12) step();

    // Reset with three commands in flight, then a fresh add.
    for (int p = 0; p < 3; p++) drv(p, 1, 100 + p);
    step();
    for (int p = 0; p < 3; p++) drv(p, 0, 1);
    step();
    idle_all();
    step();
    step();
    pulse_reset();
    repeat (8) step();
    drv(1, 1, 10);
    step();
    drv(1, 0, 20);
    step();
    idle_all();
    step();
    step();
    chk("post_reset_resp", longint'(bus.out_resp), 64'h04);
    chk("post_reset_data", longint'(bus.out_data[2*DW-1:DW]), 30);
    repeat (6) step();

    // Random traffic on all ports.
    for (int i = 0; i < 1500; i++) begin
      for (int p = 0; p < NP; p++) drv(p, rand_cmd(), rand_data());
      step();
    end
    idle_all();
    repeat (40) step();
    for (int p = 0; p < NP; p++) begin
      chk($sformatf("drain_empty_p%0d", p), longint'(expq[p].size()), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
